// File: rtl/btn_debounce_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2,
      REPEAT  = 2'd3
   } btn_state_e;

   // Convert a duration in ms into a number of sample ticks.
   function automatic int unsigned ms_to_ticks(input int unsigned ms, input int unsigned sample_hz);
      return (ms * sample_hz) / 1000;
   endfunction

   // Bits needed to hold values 0..max_val (never less than one).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF sync, sample shift register, hysteresis, edge pulses, hold FSM.
// Optional auto-repeat of the long pulse when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned LONG_TICKS   = 1000
`ifdef BTN_AUTOREPEAT_EN
   ,parameter int unsigned REPEAT_TICKS = 200
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic tick,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int unsigned HW = cnt_width(LONG_TICKS);

   logic [1:0]       sync_q;
   logic [DEPTH-1:0] samples_q;
   logic             tick_d_q;
   logic             level_q, rise_q, fall_q, long_q;
   logic             level_next;

   btn_state_e       state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             long_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RW = cnt_width(REPEAT_TICKS);
   logic [RW-1:0]    rep_q, rep_d;
`endif

   // Level only moves on a unanimous window; mixed samples hold it.
   assign level_next = (&samples_q)  ? 1'b1 :
                       (~|samples_q) ? 1'b0 : level_q;

   // Synchroniser, sampling and level/edge registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         samples_q <= '0;
         tick_d_q  <= 1'b0;
         level_q   <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn};
         tick_d_q <= tick;
         if (tick) samples_q <= {samples_q[DEPTH-2:0], sync_q[1]};
         level_q  <= level_next;
         rise_q   <= level_next & ~level_q;
         fall_q   <= ~level_next & level_q;
      end
   end

   // FSM state and counters; the delayed tick lines hold events up with level changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         long_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         long_q  <= long_d;
`ifdef BTN_AUTOREPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      long_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         IDLE: begin
            if (level_next) begin
               state_d = PRESSED;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            // A release on the threshold tick takes priority over the long pulse.
            if (!level_next) begin
               state_d = IDLE;
            end else if (tick_d_q) begin
               if (hold_q == HW'(LONG_TICKS - 1)) begin
                  long_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  state_d = REPEAT;
                  rep_d   = '0;
`else
                  state_d = HELD;
`endif
               end
               if (hold_q != HW'(LONG_TICKS)) hold_d = hold_q + HW'(1);
            end
         end
         HELD: begin
            if (!level_next) state_d = IDLE;
         end
         REPEAT: begin
`ifdef BTN_AUTOREPEAT_EN
            if (!level_next) begin
               state_d = IDLE;
            end else if (tick_d_q) begin
               if (rep_q == RW'(REPEAT_TICKS - 1)) begin
                  long_d = 1'b1;
                  rep_d  = '0;
               end else begin
                  rep_d  = rep_q + RW'(1);
               end
            end
`else
            state_d = IDLE;
`endif
         end
      endcase
   end

   assign level      = level_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign long_press = long_q;

endmodule

// File: rtl/button_debounce_multi.sv
// NUM_BTN-channel button debouncer with shared sample tick.
// Define BTN_AUTOREPEAT_EN to repeat o_long every REPEAT_MS while a button stays held.
module button_debounce_multi
   import btn_debounce_pkg::*;
#(
   parameter int unsigned NUM_BTN   = 4,
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned SAMPLE_HZ = 1000,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LONG_MS   = 1000,
   parameter int unsigned REPEAT_MS = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_long,
   output logic               o_tick
);

   localparam int unsigned TICK_DIV     = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned TW           = cnt_width(TICK_DIV - 1);
   localparam int unsigned LONG_TICKS   = ms_to_ticks(LONG_MS, SAMPLE_HZ);
   localparam int unsigned REPEAT_TICKS = ms_to_ticks(REPEAT_MS, SAMPLE_HZ);

   if (TICK_DIV < 2 || DEPTH < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("button_debounce_multi: TICK_DIV and DEPTH must be >= 2, tick counts >= 1");
   end

   logic [TW-1:0] tick_cnt_q;
   logic          tick_q;

   // Sample strobe: high for the one clk in which the divider wraps to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b1;
      end else begin
         tick_cnt_q <= tick_cnt_q + TW'(1);
         tick_q     <= 1'b0;
      end
   end

   assign o_tick = tick_q;

   for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
      btn_debounce_ch #(
         .DEPTH        (DEPTH),
         .LONG_TICKS   (LONG_TICKS)
`ifdef BTN_AUTOREPEAT_EN
         ,.REPEAT_TICKS (REPEAT_TICKS)
`endif
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .btn        (i_btn[i]),
         .tick       (tick_q),
         .level      (o_level[i]),
         .rise       (o_press[i]),
         .fall       (o_release[i]),
         .long_press (o_long[i])
      );
   end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
Parametrised successor to the single-button debouncer. It debounces NUM_BTN raw push-button inputs, all synchronous to one clk. Per channel it provides a clean level, one-clk press and release pulses, and a long-press pulse. It sits between the board button pins and the control FSMs (stopwatch/clock/sensor mode logic), replacing the per-button instances.

Parameters:
NUM_BTN, 4, number of independent button channels
CLK_HZ, 100_000_000, system clock frequency in Hz
SAMPLE_HZ, 1000, debounce sampling rate; TICK_DIV = CLK_HZ/SAMPLE_HZ, minimum 2
DEPTH, 4, consecutive equal samples required to change the debounced level, minimum 2
LONG_MS, 1000, hold time before o_long fires, converted to LONG_TICKS = LONG_MS*SAMPLE_HZ/1000
REPEAT_MS, 200, auto-repeat period when BTN_AUTOREPEAT_EN is defined

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_btn  input  NUM_BTN  raw, asynchronous, active-high button pins
o_level  output  NUM_BTN  debounced level per channel
o_press  output  NUM_BTN  1-clk pulse on debounced 0->1
o_release  output  NUM_BTN  1-clk pulse on debounced 1->0
o_long  output  NUM_BTN  1-clk pulse when held LONG_TICKS ticks; also the repeat pulses when the feature is enabled
o_tick  output  1  shared sample strobe, exported for test and observation

Behaviour:
- Single clock domain. All flops run on clk. No derived clocks; the sample tick is a 1-clk enable.
- Reset (rst=1, async): tick counter=0, o_tick=0, sync flops=0, shift registers=0, levels=0, hold counters=0, all states=IDLE, all outputs 0.
- Tick generator: counter 0..TICK_DIV-1. o_tick=1 for exactly the one clk in which the counter wraps to 0. First tick occurs TICK_DIV clks after reset release.
- Synchroniser: 2-FF per bit on i_btn.
- Sample shift register: DEPTH bits per channel; shifts in the synced bit on o_tick only.
- Hysteresis:
  - Level goes to 1 when all DEPTH bits are 1.
  - Level goes to 0 when all DEPTH bits are 0.
  - Otherwise the level holds; mixed samples never toggle it.
- Latency: a clean edge reaches o_level 2 clks (sync) + up to DEPTH ticks + 1 clk later.
- o_press / o_release: registered level edge detect. Each is high for exactly 1 clk, in the same cycle that o_level changes. They are never both high on one channel.
- Per-channel FSM:
  - IDLE: level=0. On level 1: ->PRESSED, hold counter=0.
  - PRESSED: counter increments on o_tick. When counter reaches LONG_TICKS-1 on a tick: o_long pulse, ->HELD. Level 0: ->IDLE.
  - HELD: no further o_long (unless the feature is enabled). Level 0: ->IDLE.
- Hold counter: width $clog2(LONG_TICKS+1). It saturates and never wraps.
- Simultaneous events:
  - Channels are fully independent. Any combination of pulses may occur in the same clk.
  - If release and long threshold fall on the same tick, release wins: o_release=1, o_long=0, state ->IDLE.
- Glitch shorter than DEPTH ticks: no output activity.
- Reset mid-press: all outputs drop immediately. After release of reset, a still-held button produces a fresh o_press after DEPTH ticks.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: adds state REPEAT. On entry to HELD, the FSM goes straight to REPEAT with the repeat counter=0. Every REPEAT_TICKS ticks (REPEAT_MS*SAMPLE_HZ/1000) it emits a further 1-clk o_long pulse until level 0 (->IDLE).
- Not defined: REPEAT state and its counter are absent. Exactly one o_long per hold.

Decomposition:
- Package btn_debounce_pkg holds:
  - FSM state encoding: IDLE=2'd0, PRESSED=2'd1, HELD=2'd2, REPEAT=2'd3.
  - A constant function ms_to_ticks(ms, sample_hz).
  - A clog2-width helper.
- Top module holds the tick generator and a generate loop of NUM_BTN instances.
- Sub-module btn_debounce_ch contains one channel: synchroniser, shift register, hysteresis, edge detect, FSM and counters. It takes the tick as an input.

Test Plan:
Test parameters: CLK_HZ=1000, SAMPLE_HZ=100 (TICK_DIV=10), DEPTH=4, LONG_MS=100 (10 ticks), REPEAT_MS=30 (3 ticks).
- Reset then idle 100 clks -> o_tick period exactly 10 clks; all outputs 0.
- i_btn[0] held 1 -> o_level[0] rises within 2+40+1 clks; o_press[0] high exactly 1 clk; other channels quiet.
- i_btn[1] toggled every 15 clks (shorter than 4 ticks) -> o_level[1], o_press[1] and o_release[1] stay 0 throughout.
- i_btn[2] held for 15 ticks then released -> one o_long[2] 10 ticks after o_press; then o_release[2]. With BTN_AUTOREPEAT_EN, additional o_long[2] pulses every 3 ticks until release.
- Press all four channels in the same clk -> four o_press bits in the same cycle; assert rst mid-hold -> all outputs 0 same cycle; re-press detected after release of reset.
- Release timed to the tick of the long threshold -> o_release=1 and o_long=0 on that channel.
